// File: rtl/btn_debounce_pkg.sv
// Shared project constants for the push-button debouncer.
package btn_debounce_pkg;
    localparam int unsigned DEBOUNCE_SAMPLES_DEFAULT = 3;
endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: 2-FF synchronizer, stability counter, level and edge pulses.
module debounce_cell
    import btn_debounce_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (strobe) begin
                // Any strobe that sees the current level breaks the run.
                if (s2 == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    level <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                    fall  <= ~s2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel debouncer sampling on rising edges of the divided tick.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned STABLE_SAMPLES = DEBOUNCE_SAMPLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic tick_q;
    logic strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
        end
    end

    assign strobe = tick & ~tick_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .strobe (strobe),
            .raw    (raw_in[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button/switch debouncer that consumes the slow square wave produced by the board clock divider and uses its rising edges as sample strobes. Each channel accepts a raw, asynchronous pad input. The block emits a clean level only after the input has held a new value for a programmable number of consecutive samples. It also emits one-cycle rise/fall pulses for the CPU's I/O register block.

## Interface
Parameters:
- WIDTH, 4, number of independent channels (≥1)
- STABLE_SAMPLES, 3, consecutive strobes a new value must persist before acceptance (≥1)

Ports:
- clk  input  1  system clock; every register is clocked on its rising edge
- rst  input  1  reset, synchronous and active-high
- tick  input  1  divided clock from the clock divider, synchronous to clk; its rising edge is the sample strobe
- raw_in  input  WIDTH  raw pad inputs, asynchronous
- level  output  WIDTH  debounced level, registered
- rise  output  WIDTH  one-cycle pulse when level goes 0→1, registered
- fall  output  WIDTH  one-cycle pulse when level goes 1→0, registered

## Operation
- **Strobe detect:** tick_q <= tick every cycle; strobe = tick & ~tick_q (combinational, one cycle wide).
- **Synchronizer:** a 2-FF synchronizer per channel, raw_in → s1 → s2. The s2 value is the "sampled" input and is updated every cycle, not only on strobes.
- **Per-channel counter:** cnt has width $clog2(STABLE_SAMPLES+1). On strobe:
  - if s2 == level: cnt <= 0
  - else if cnt == STABLE_SAMPLES-1: level <= s2, cnt <= 0, and rise (if s2=1) or fall (if s2=0) <= 1
  - else: cnt <= cnt+1
- **Non-strobe cycles:** cnt and level hold; rise/fall <= 0.
- **Pulse width:** rise/fall are high for exactly one clk cycle, never both at once on a channel.
- **Glitch rejection:** any strobe on which s2 equals level clears cnt, so a bounce resets the run.
- **Counter range:** cnt never exceeds STABLE_SAMPLES-1 and never wraps.
- **Channel independence:** channels are fully independent; simultaneous acceptance on several channels asserts all of their pulses in the same cycle.

## Timing
- **Reset values:** on rst=1 at a clk edge, tick_q, s1, s2, cnt, level, rise and fall all go to 0. rst has priority over strobe.
- **First strobe after reset:** because tick_q resets to 0, if tick is high on the first cycle after reset, that cycle is a strobe.
- **Synchronizer latency:** raw_in change at edge t is visible in s2 after edge t+2.
- **Acceptance latency:** with s2 stable and differing from level, level and rise/fall update on the clk edge ending the STABLE_SAMPLES-th strobe cycle.
- **STABLE_SAMPLES=1:** acceptance on the first differing strobe.
- **Mid-operation reset:** partially counted runs are discarded, and no pulse is emitted on or after the reset edge.
- **Held tick:** tick held high produces only one strobe; tick low produces none.

## Structure
- Top btn_debounce holds the tick edge detector and a generate loop over WIDTH.
- Sub-module debounce_cell, one per channel, holds the synchronizer, cnt, level, rise and fall. It takes clk, rst, strobe and raw bit as inputs.
- The shared project constants package holds DEBOUNCE_SAMPLES_DEFAULT (3); no typedefs are needed.

## Test plan
All scenarios use WIDTH=4, STABLE_SAMPLES=3, tick period 10 clk (5 high/5 low).
- **Reset:** assert rst 3 cycles with raw_in=4'hF → level=0, rise=0, fall=0 throughout reset. With the next strobes, level=4'hF after the 3rd strobe, and rise=4'hF for exactly one cycle.
- **Clean press:** ch0 goes 0→1 and is held → level[0]=1 on the edge ending the 3rd strobe after s2 changes, rise[0] pulses once, and channels 1-3 stay 0.
- **Bounce:** ch1 toggles 1,0,1,0 on successive strobes, then holds 1 → no change until 3 consecutive strobes see 1, then a single rise[1].
- **Release and simultaneous:** ch0 and ch2 both released in the same cycle → fall[0] and fall[2] are asserted in the same cycle, one cycle wide, and level=4'b0000.
- **Mid-run reset:** ch3 is held high for 2 strobes, then rst pulses → level[3]=0 and no rise. Acceptance then needs 3 fresh strobes.
- **Edge cases:** tick held high for 40 cycles gives exactly one strobe. With STABLE_SAMPLES=1, level follows on the first differing strobe.
